// File: rtl/fma_pkg.sv
// Shared format constants and width helpers for the FMA add pipeline.
// The default payload struct matches the half-precision format; the top redeclares it at its own widths.
package fma_pkg;

  localparam int NF_HALF   = 10;
  localparam int NE_HALF   = 5;
  localparam int NF_BF16   = 7;
  localparam int NE_BF16   = 8;
  localparam int NF_SINGLE = 23;
  localparam int NE_SINGLE = 8;

  function automatic int pw_of(input int nf);
    return 2 * nf + 2;
  endfunction

  function automatic int sw_of(input int nf);
    return 3 * nf + 4;
  endfunction

  function automatic int ew_of(input int ne);
    return ne + 2;
  endfunction

  function automatic int lw_of(input int nf);
    return $clog2(sw_of(nf) + 1);
  endfunction

  localparam int PW_HALF = pw_of(NF_HALF);
  localparam int SW_HALF = sw_of(NF_HALF);
  localparam int EW_HALF = ew_of(NE_HALF);
  localparam int LW_HALF = lw_of(NF_HALF);

  typedef struct packed {
    logic [SW_HALF-1:0] am_inv;
    logic [PW_HALF-1:0] pm_killed;
    logic               cin;
    logic               ps;
    logic [NE_HALF-1:0] ze;
    logic [EW_HALF-1:0] pe;
    logic               kill_prod;
  } s1_half_t;

endpackage

// File: rtl/fma_lzc.sv
// Leading-zero counter over a W-bit word; an all-zero word reports W.
module fma_lzc #(
  parameter int W  = 34,
  parameter int LW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [LW-1:0] cnt
);

  // NOTE: combinational loops use blocking assignments so the last
  // iteration (the highest set bit) wins; the default first avoids a latch.
  always_comb begin
    cnt = LW'(W);
    for (int i = 0; i < W; i++) begin
      if (d[i]) cnt = LW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fma_add_pipe.sv
// Two-stage FMA add: invert/kill in S1, add and take magnitude in S2, valid/ready on both sides.
// Define FMA_ADD_LZC_EN to add a registered leading-zero count of the sum magnitude.
module fma_add_pipe
  import fma_pkg::*;
#(
  parameter  int NF = NF_HALF,
  parameter  int NE = NE_HALF,
  localparam int PW = pw_of(NF),
  localparam int SW = sw_of(NF),
  localparam int EW = ew_of(NE),
  localparam int LW = lw_of(NF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] Am,
  input  logic [PW-1:0] Pm,
  input  logic [NE-1:0] Ze,
  input  logic [EW-1:0] Pe,
  input  logic          Ps,
  input  logic          KillProd,
  input  logic          ASticky,
  input  logic          InvA,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] Sm,
  output logic [EW-1:0] Se,
  output logic          Ss
`ifdef FMA_ADD_LZC_EN
  ,
  output logic [LW-1:0] Lzc
`endif
);

  typedef struct packed {
    logic [SW-1:0] am_inv;
    logic [PW-1:0] pm_killed;
    logic          cin;
    logic          ps;
    logic [NE-1:0] ze;
    logic [EW-1:0] pe;
    logic          kill_prod;
  } s1_t;

  localparam logic [SW-1:0] ONE = SW'(1);

  logic en1, en2;
  logic v1, v2;
  s1_t  s1_d, s1_q;

  assign en2       = ~v2 | out_ready;
  assign en1       = ~v1 | en2;
  assign in_ready  = en1;
  assign out_valid = v2;

  // ---------------- S1: operand conditioning ----------------
  assign s1_d = '{
    am_inv:    InvA ? ~Am : Am,
    pm_killed: KillProd ? '0 : Pm,
    cin:       (~ASticky | KillProd) & InvA,
    ps:        Ps,
    ze:        Ze,
    pe:        Pe,
    kill_prod: KillProd
  };

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset)    v1 <= 1'b0;
    else if (en1) v1 <= in_valid;
  end

  // NOTE: the S1 payload is deliberately not reset; v1 qualifies it and
  // leaving it unreset keeps reset fan-out off the wide datapath.
  always_ff @(posedge clk) begin
    if (in_valid & en1) s1_q <= s1_d;
  end

  // ---------------- S2: add, magnitude, sign/exponent select ----------------
  logic [SW-1:0] pre_sum;
  logic          neg_sum;
  logic [SW-1:0] sm_d;
  logic [EW-1:0] se_d;
  logic          ss_d;

  assign pre_sum = {{(SW-PW-2){1'b0}}, s1_q.pm_killed, 2'b00}
                 + s1_q.am_inv
                 + {{(SW-1){1'b0}}, s1_q.cin};
  assign neg_sum = pre_sum[SW-1];
  assign sm_d    = neg_sum ? (~pre_sum + ONE) : pre_sum;
  assign ss_d    = s1_q.ps ^ neg_sum;
  assign se_d    = s1_q.kill_prod ? {{(EW-NE){1'b0}}, s1_q.ze} : s1_q.pe;

`ifdef FMA_ADD_LZC_EN
  logic [LW-1:0] lzc_d;

  fma_lzc #(.W(SW), .LW(LW)) u_lzc (
    .d   (sm_d),
    .cnt (lzc_d)
  );

  always_ff @(posedge clk) begin
    if (reset)              Lzc <= '0;
    else if (v1 & en2)      Lzc <= lzc_d;
  end
`endif

  // Outputs come straight from these registers, so a stall holds them stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2 <= 1'b0;
      Sm <= '0;
      Se <= '0;
      Ss <= 1'b0;
    end else begin
      if (en2) v2 <= v1;
      if (v1 & en2) begin
        Sm <= sm_d;
        Se <= se_d;
        Ss <= ss_d;
      end
    end
  end

endmodule

// File: tb/tb_fma_add_pipe.sv
// Directed testbench for fma_add_pipe at NF=10, NE=5 (SW=34, PW=22, EW=7).
// Covers latency, add/subtract/kill datapath, backpressure, mid-flight reset and optional Lzc.
module tb_fma_add_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] am;
  logic [21:0] pm;
  logic [4:0]  ze;
  logic [6:0]  pe;
  logic        ps;
  logic        kill_prod;
  logic        a_sticky;
  logic        inv_a;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] sm;
  logic [6:0]  se;
  logic        ss;
`ifdef FMA_ADD_LZC_EN
  logic [5:0]  lzc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fma_add_pipe #(.NF(10), .NE(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Am        (am),
    .Pm        (pm),
    .Ze        (ze),
    .Pe        (pe),
    .Ps        (ps),
    .KillProd  (kill_prod),
    .ASticky   (a_sticky),
    .InvA      (inv_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sm        (sm),
    .Se        (se),
    .Ss        (ss)
`ifdef FMA_ADD_LZC_EN
    ,
    .Lzc       (lzc)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one beat on a falling edge and records what the DUT shows on the
  // next three falling edges (after 1, 2 and 3 rising edges).
  task automatic single_beat(
    input  logic [33:0] a_m, input logic [21:0] p_m,
    input  logic [4:0]  z_e, input logic [6:0]  p_e,
    input  logic p_s, input logic kill, input logic sticky, input logic inv,
    output logic rdy, output logic ov_early, output logic ov_on, output logic ov_late,
    output logic [33:0] o_sm, output logic [6:0] o_se, output logic o_ss,
    output logic [5:0] o_lzc);
    @(negedge clk);
    am = a_m; pm = p_m; ze = z_e; pe = p_e; ps = p_s;
    kill_prod = kill; a_sticky = sticky; inv_a = inv;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 rdy = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    ov_early = out_valid;
    @(negedge clk);
    ov_on = out_valid;
    o_sm  = sm;
    o_se  = se;
    o_ss  = ss;
`ifdef FMA_ADD_LZC_EN
    o_lzc = lzc;
`else
    o_lzc = '0;
`endif
    @(negedge clk);
    ov_late = out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    am = '0; pm = '0; ze = '0; pe = '0; ps = 1'b0;
    kill_prod = 1'b0; a_sticky = 1'b0; inv_a = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (sm !== 34'h0 || se !== 7'h0 || ss !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got sm=%h se=%h ss=%b want all zero", sm, se, ss);
    end
`ifdef FMA_ADD_LZC_EN
    n_checks++;
    if (lzc !== 6'd0) begin n_fail++; $display("FAIL reset_lzc: got %0d want 0", lzc); end
`endif
  endtask

  task automatic test_effective_add();
    logic rdy, ov0, ov1, ov2, o_ss;
    logic [33:0] o_sm; logic [6:0] o_se; logic [5:0] o_lzc;
    single_beat(34'h1000, 22'h100, 5'd3, 7'd20, 1'b1, 1'b0, 1'b0, 1'b0,
                rdy, ov0, ov1, ov2, o_sm, o_se, o_ss, o_lzc);
    n_checks++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL add_in_ready: got %b want 1", rdy); end
    n_checks++;
    if (ov0 !== 1'b0) begin n_fail++; $display("FAIL add_latency_early: out_valid got %b want 0", ov0); end
    n_checks++;
    if (ov1 !== 1'b1) begin n_fail++; $display("FAIL add_latency: out_valid got %b want 1", ov1); end
    n_checks++;
    if (ov2 !== 1'b0) begin n_fail++; $display("FAIL add_single_cycle: out_valid got %b want 0", ov2); end
    n_checks++;
    if (o_sm !== 34'h1400 || o_se !== 7'd20 || o_ss !== 1'b1) begin
      n_fail++; $display("FAIL add_result: got sm=%h se=%0d ss=%b want sm=1400 se=20 ss=1", o_sm, o_se, o_ss);
    end
`ifdef FMA_ADD_LZC_EN
    n_checks++;
    if (o_lzc !== 6'd21) begin n_fail++; $display("FAIL add_lzc: got %0d want 21", o_lzc); end
`endif
  endtask

  task automatic test_subtract();
    logic rdy, ov0, ov1, ov2, o_ss;
    logic [33:0] o_sm; logic [6:0] o_se; logic [5:0] o_lzc;
    // Negative result: 0x400 - 0x2000 -> magnitude 0x1C00, sign flipped.
    single_beat(34'h2000, 22'h100, 5'd1, 7'd40, 1'b0, 1'b0, 1'b0, 1'b1,
                rdy, ov0, ov1, ov2, o_sm, o_se, o_ss, o_lzc);
    n_checks++;
    if (ov1 !== 1'b1 || o_sm !== 34'h1C00 || o_ss !== 1'b1 || o_se !== 7'd40) begin
      n_fail++; $display("FAIL sub_negative: got v=%b sm=%h ss=%b se=%0d want v=1 sm=1c00 ss=1 se=40",
                         ov1, o_sm, o_ss, o_se);
    end
    // Positive result with sticky set drops the +1: 0x4000 + ~0x2000 = 0x1FFF.
    single_beat(34'h2000, 22'h1000, 5'd1, 7'd33, 1'b1, 1'b0, 1'b1, 1'b1,
                rdy, ov0, ov1, ov2, o_sm, o_se, o_ss, o_lzc);
    n_checks++;
    if (ov1 !== 1'b1 || o_sm !== 34'h1FFF || o_ss !== 1'b1 || o_se !== 7'd33) begin
      n_fail++; $display("FAIL sub_sticky: got v=%b sm=%h ss=%b se=%0d want v=1 sm=1fff ss=1 se=33",
                         ov1, o_sm, o_ss, o_se);
    end
    // Same operands without sticky: exact 0x4000 - 0x2000.
    single_beat(34'h2000, 22'h1000, 5'd1, 7'd33, 1'b0, 1'b0, 1'b0, 1'b1,
                rdy, ov0, ov1, ov2, o_sm, o_se, o_ss, o_lzc);
    n_checks++;
    if (ov1 !== 1'b1 || o_sm !== 34'h2000 || o_ss !== 1'b0) begin
      n_fail++; $display("FAIL sub_positive: got v=%b sm=%h ss=%b want v=1 sm=2000 ss=0", ov1, o_sm, o_ss);
    end
  endtask

  task automatic test_killed_product();
    logic rdy, ov0, ov1, ov2, o_ss;
    logic [33:0] o_sm; logic [6:0] o_se; logic [5:0] o_lzc;
    single_beat(34'h155, 22'h3FFFFF, 5'd15, 7'd99, 1'b1, 1'b1, 1'b0, 1'b0,
                rdy, ov0, ov1, ov2, o_sm, o_se, o_ss, o_lzc);
    n_checks++;
    if (ov1 !== 1'b1 || o_sm !== 34'h155 || o_se !== 7'd15 || o_ss !== 1'b1) begin
      n_fail++; $display("FAIL kill_add: got v=%b sm=%h se=%0d ss=%b want v=1 sm=155 se=15 ss=1",
                         ov1, o_sm, o_se, o_ss);
    end
    // Killed product with subtraction: carry-in forced despite sticky, result is -Am.
    single_beat(34'h155, 22'h3FFFFF, 5'd15, 7'd99, 1'b0, 1'b1, 1'b1, 1'b1,
                rdy, ov0, ov1, ov2, o_sm, o_se, o_ss, o_lzc);
    n_checks++;
    if (ov1 !== 1'b1 || o_sm !== 34'h155 || o_se !== 7'd15 || o_ss !== 1'b1) begin
      n_fail++; $display("FAIL kill_sub: got v=%b sm=%h se=%0d ss=%b want v=1 sm=155 se=15 ss=1",
                         ov1, o_sm, o_se, o_ss);
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] exp_sm [4];
    logic [6:0]  exp_se [4];
    logic        exp_ss [4];
    int sent = 0;
    int recv = 0;
    for (int i = 0; i < 4; i++) begin
      exp_sm[i] = 34'h10 + 34'(i);
      exp_se[i] = 7'(i + 1);
      exp_ss[i] = i[0];
    end
    pm = '0; kill_prod = 1'b0; a_sticky = 1'b0; inv_a = 1'b0; ze = 5'd0;
    for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      #1;
      if (out_valid) begin
        n_checks++;
        if (sm !== exp_sm[recv] || se !== exp_se[recv] || ss !== exp_ss[recv]) begin
          n_fail++; $display("FAIL bp_beat%0d cyc%0d: got sm=%h se=%0d ss=%b want sm=%h se=%0d ss=%b",
                             recv, cyc, sm, se, ss, exp_sm[recv], exp_se[recv], exp_ss[recv]);
        end
        if (out_ready) recv++;
      end
      if (sent < 4) begin
        am = exp_sm[sent]; pe = exp_se[sent]; ps = exp_ss[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
      end
      if (in_valid && in_ready) sent++;
    end
    n_checks++;
    if (sent != 4 || recv != 4) begin
      n_fail++; $display("FAIL bp_counts: got sent=%0d recv=%0d want 4 and 4", sent, recv);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0; inv_a = 1'b0; kill_prod = 1'b0; pm = '0;
    am = 34'h777; pe = 7'd5; ps = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    am = 34'h888;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_pipe_full: got out_valid=%b in_ready=%b want 1 and 0", out_valid, in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale_beat%0d: out_valid got %b want 0", i, out_valid); end
      @(negedge clk);
    end
  endtask

`ifdef FMA_ADD_LZC_EN
  task automatic test_lzc_zero();
    logic rdy, ov0, ov1, ov2, o_ss;
    logic [33:0] o_sm; logic [6:0] o_se; logic [5:0] o_lzc;
    single_beat(34'h0, 22'h0, 5'd2, 7'd9, 1'b0, 1'b0, 1'b0, 1'b0,
                rdy, ov0, ov1, ov2, o_sm, o_se, o_ss, o_lzc);
    n_checks++;
    if (ov1 !== 1'b1 || o_sm !== 34'h0 || o_lzc !== 6'd34) begin
      n_fail++; $display("FAIL lzc_zero: got v=%b sm=%h lzc=%0d want v=1 sm=0 lzc=34", ov1, o_sm, o_lzc);
    end
    single_beat(34'h2_0000_0000, 22'h0, 5'd2, 7'd9, 1'b0, 1'b0, 1'b0, 1'b0,
                rdy, ov0, ov1, ov2, o_sm, o_se, o_ss, o_lzc);
    n_checks++;
    if (o_lzc !== 6'd0) begin n_fail++; $display("FAIL lzc_msb: got %0d want 0", o_lzc); end
  endtask
`endif

  initial begin
    test_reset();
    test_effective_add();
    test_subtract();
    test_killed_product();
    test_backpressure();
    test_reset_midflight();
`ifdef FMA_ADD_LZC_EN
    test_lzc_zero();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
